// File: rtl/mem_arb_rr_if.sv
// mem_arb_rr_if: user request/return bus plus single-port RAM bus.
// slave = arbiter side, master = users + RAM side.
interface mem_arb_rr_if #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int N  = 4
) ();
  logic [N-1:0]         v_i;
  logic [N-1:0]         r_nw;
  logic [N-1:0][AW-1:0] a_i;
  logic [N-1:0][DW-1:0] d_i;
  logic [N-1:0]         f_o;
  logic [N-1:0]         ovf_o;
  logic [N-1:0]         v_o;
  logic [AW-1:0]        a_o;
  logic [DW-1:0]        d_o;
  logic                 ram_v;
  logic                 ram_we;
  logic [AW-1:0]        ram_a;
  logic [DW-1:0]        ram_d;
  logic [DW-1:0]        ram_q;

  modport slave (
    input  v_i, r_nw, a_i, d_i, ram_q,
    output f_o, ovf_o, v_o, a_o, d_o,
    output ram_v, ram_we, ram_a, ram_d
  );

  modport master (
    output v_i, r_nw, a_i, d_i, ram_q,
    input  f_o, ovf_o, v_o, a_o, d_o,
    input  ram_v, ram_we, ram_a, ram_d
  );
endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: N-port RAM arbiter, per-port request FIFOs,
// fixed-priority (RR=0) or round-robin (RR=1) grant, one cmd/cycle.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   v_i/r_nw/a_i/d_i requests, f_o/ovf_o FIFO status,
//   v_o/a_o/d_o read return, ram_v/ram_we/ram_a/ram_d/ram_q RAM.
// MEM_ARB_RR_STAT_EN adds gnt_cnt_o (per-port grant counters)
// and starve_o (port waiting >= 2*N cycles).
module mem_arb_rr #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int N  = 4,
  parameter int D  = 8,
  parameter int RL = 1,
  parameter int RR = 1
) (
  input  logic clk,
  input  logic rst,
  mem_arb_rr_if.slave bus
`ifdef MEM_ARB_RR_STAT_EN
  ,
  output logic [N-1:0][15:0] gnt_cnt_o,
  output logic [N-1:0]       starve_o
`endif
);
  localparam int PW = $clog2(D) + 1;
  localparam int IW = $clog2(N);
  localparam int EW = DW + AW + 1;

  // entry = {data, addr, r_nw}
  logic [EW-1:0] mem_q [N][D];
  logic [PW-1:0] wp_q [N];
  logic [PW-1:0] wp_d [N];
  logic [PW-1:0] rp_q [N];
  logic [PW-1:0] rp_d [N];
  logic [EW-1:0] head [N];
  logic [N-1:0]  f_q, f_d;
  logic [N-1:0]  ovf_q, ovf_d;
  logic [N-1:0]  push, ne, gnt;

  logic [IW-1:0] ptr_q, ptr_d, win;
  logic          any;
  logic [EW-1:0] hw;

  logic          ram_v_q, ram_we_q;
  logic [AW-1:0] ram_a_q;
  logic [DW-1:0] ram_d_q;

  logic [RL:0]         rv_q;
  logic [RL:0][N-1:0]  oh_q;
  logic [RL:0][AW-1:0] ra_q;
  logic [N-1:0]        v_q;
  logic [AW-1:0]       a_q;
  logic [DW-1:0]       d_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ne[i]   = wp_q[i] != rp_q[i];
      head[i] = mem_q[i][rp_q[i][PW-2:0]];
      push[i] = bus.v_i[i] && !f_q[i];
    end
  end

  // Round-robin scans downward so the last hit is
  // the first non-empty port after the pointer.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    any = 1'b0;
    if (RR == 0) begin
      for (int i = 0; i < N; i++) begin
        if (ne[i]) begin
          win = IW'(i);
          any = 1'b1;
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        idx = (int'(ptr_q) + k) % N;
        if (ne[idx]) begin
          win = IW'(idx);
          any = 1'b1;
        end
      end
    end
    gnt   = any ? (N'(1) << win) : '0;
    ptr_d = any ? win : ptr_q;
  end

  assign hw = head[win];

  // f_o is registered: a pop never frees a slot
  // for a push in the same cycle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wp_d[i]  = wp_q[i] + PW'(push[i]);
      rp_d[i]  = rp_q[i] + PW'(gnt[i]);
      f_d[i]   = (wp_d[i] - rp_d[i]) == PW'(D);
      ovf_d[i] = ovf_q[i] | (bus.v_i[i] & f_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i])
        mem_q[i][wp_q[i][PW-2:0]] <=
          {bus.d_i[i], bus.a_i[i], bus.r_nw[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
      end
      f_q   <= '0;
      ovf_q <= '0;
      ptr_q <= IW'(N - 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        wp_q[i] <= wp_d[i];
        rp_q[i] <= rp_d[i];
      end
      f_q   <= f_d;
      ovf_q <= ovf_d;
      ptr_q <= ptr_d;
    end
  end

  // Stage 0 of the return pipe lines up with the
  // command cycle; stage RL with ram_q valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_v_q  <= 1'b0;
      ram_we_q <= 1'b0;
      ram_a_q  <= '0;
      ram_d_q  <= '0;
      rv_q     <= '0;
      oh_q     <= '0;
      ra_q     <= '0;
      v_q      <= '0;
      a_q      <= '0;
      d_q      <= '0;
    end else begin
      ram_v_q <= any;
      if (any) begin
        ram_we_q <= ~hw[0];
        ram_a_q  <= hw[AW:1];
        ram_d_q  <= hw[EW-1:AW+1];
      end
      rv_q[0] <= any & hw[0];
      oh_q[0] <= gnt;
      ra_q[0] <= hw[AW:1];
      for (int k = 1; k <= RL; k++) begin
        rv_q[k] <= rv_q[k-1];
        oh_q[k] <= oh_q[k-1];
        ra_q[k] <= ra_q[k-1];
      end
      v_q <= rv_q[RL] ? oh_q[RL] : '0;
      if (rv_q[RL]) begin
        a_q <= ra_q[RL];
        d_q <= bus.ram_q;
      end
    end
  end

  assign bus.f_o    = f_q;
  assign bus.ovf_o  = ovf_q;
  assign bus.v_o    = v_q;
  assign bus.a_o    = a_q;
  assign bus.d_o    = d_q;
  assign bus.ram_v  = ram_v_q;
  assign bus.ram_we = ram_we_q;
  assign bus.ram_a  = ram_a_q;
  assign bus.ram_d  = ram_d_q;

`ifdef MEM_ARB_RR_STAT_EN
  localparam int SW = $clog2(2 * N) + 1;

  logic [N-1:0][15:0] gc_q;
  logic [SW-1:0]      sc_q [N];

  // sc_q saturates at 2*N waiting cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gc_q <= '0;
      for (int i = 0; i < N; i++) sc_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) gc_q[i] <= gc_q[i] + 16'd1;
        if (!ne[i] || gnt[i])
          sc_q[i] <= '0;
        else if (sc_q[i] != SW'(2 * N))
          sc_q[i] <= sc_q[i] + SW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      starve_o[i] = sc_q[i] == SW'(2 * N);
  end

  assign gnt_cnt_o = gc_q;
`else
`endif
endmodule

// File: tb/tb_mem_arb_rr.sv
// tb_mem_arb_rr: directed bench, u0 = RR/RL=1, u1 = fixed prio/RL=3,
// both fed the same requests, each with its own RAM model.
module tb_mem_arb_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n2a, n2b;
  logic [15:0] last2;

  always #5 clk = ~clk;

  mem_arb_rr_if #(.AW(16), .DW(16), .N(4)) b0 ();
  mem_arb_rr_if #(.AW(16), .DW(16), .N(4)) b1 ();

  assign b1.v_i  = b0.v_i;
  assign b1.r_nw = b0.r_nw;
  assign b1.a_i  = b0.a_i;
  assign b1.d_i  = b0.d_i;

`ifdef MEM_ARB_RR_STAT_EN
  logic [3:0][15:0] gc0, gc1;
  logic [3:0]       sv0, sv1;
  mem_arb_rr #(.RL(1), .RR(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0),
    .gnt_cnt_o(gc0), .starve_o(sv0));
  mem_arb_rr #(.RL(3), .RR(0)) u1 (
    .clk(clk), .rst(rst), .bus(b1),
    .gnt_cnt_o(gc1), .starve_o(sv1));
`else
  mem_arb_rr #(.RL(1), .RR(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0));
  mem_arb_rr #(.RL(3), .RR(0)) u1 (
    .clk(clk), .rst(rst), .bus(b1));
`endif

  // RAM models: unwritten words read as A000|addr.
  logic [15:0]   m0 [1024];
  logic [15:0]   m1 [1024];
  logic [1023:0] w0, w1;
  logic [15:0]   q0;
  logic [15:0]   q1 [3];

  always @(posedge clk) begin
    if (rst) w0 <= '0;
    else if (b0.ram_v && b0.ram_we) begin
      m0[b0.ram_a[9:0]] <= b0.ram_d;
      w0[b0.ram_a[9:0]] <= 1'b1;
    end
    q0 <= w0[b0.ram_a[9:0]] ? m0[b0.ram_a[9:0]]
        : (16'hA000 | {6'd0, b0.ram_a[9:0]});
  end

  always @(posedge clk) begin
    if (rst) w1 <= '0;
    else if (b1.ram_v && b1.ram_we) begin
      m1[b1.ram_a[9:0]] <= b1.ram_d;
      w1[b1.ram_a[9:0]] <= 1'b1;
    end
    q1[0] <= w1[b1.ram_a[9:0]] ? m1[b1.ram_a[9:0]]
           : (16'hA000 | {6'd0, b1.ram_a[9:0]});
    q1[1] <= q1[0];
    q1[2] <= q1[1];
  end

  assign b0.ram_q = q0;
  assign b1.ram_q = q1[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", t, o, e);
    end
  endtask

  task automatic idle();
    b0.v_i  = '0;
    b0.r_nw = '0;
  endtask

  task automatic do_rst();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] e0(input int j);
    return 16'(256 * (j % 4) + j / 4);
  endfunction

  function automatic logic [15:0] e1(input int j);
    return 16'(256 * (3 - j / 4) + j % 4);
  endfunction

  initial begin
    b0.v_i  = '0;
    b0.r_nw = '0;
    b0.a_i  = '0;
    b0.d_i  = '0;
    tick();
    tick();
    chk("rst_f",     b0.f_o, 0);
    chk("rst_ovf",   b0.ovf_o, 0);
    chk("rst_v",     b0.v_o, 0);
    chk("rst_a",     b0.a_o, 0);
    chk("rst_d",     b0.d_o, 0);
    chk("rst_ramv",  b0.ram_v, 0);
    chk("rst_ramwe", b0.ram_we, 0);
    chk("rst_rama",  b0.ram_a, 0);
    chk("rst_ramd",  b0.ram_d, 0);
    chk("rst_v1",    b1.v_o, 0);
    chk("rst_ramv1", b1.ram_v, 0);
    rst = 1'b0;

    // single write then read on port 1
    b0.v_i = 4'b0010;
    b0.a_i[1] = 16'h0010;
    b0.d_i[1] = 16'hBEEF;
    tick();
    idle();
    chk("wr_early", b0.ram_v, 0);
    tick();
    chk("wr_ramv",  b0.ram_v, 1);
    chk("wr_ramwe", b0.ram_we, 1);
    chk("wr_rama",  b0.ram_a, 16'h0010);
    chk("wr_ramd",  b0.ram_d, 16'hBEEF);
    chk("wr_ramv1", b1.ram_v, 1);
    chk("wr_rama1", b1.ram_a, 16'h0010);
    b0.v_i = 4'b0010;
    b0.r_nw = 4'b0010;
    tick();
    idle();
    tick();
    chk("rd_ramv",  b0.ram_v, 1);
    chk("rd_ramwe", b0.ram_we, 0);
    chk("rd_rama",  b0.ram_a, 16'h0010);
    tick();
    chk("rd_v_early", b0.v_o, 0);
    tick();
    chk("rd_v",  b0.v_o, 4'b0010);
    chk("rd_a",  b0.a_o, 16'h0010);
    chk("rd_d",  b0.d_o, 16'hBEEF);
    chk("rd_v1_early", b1.v_o, 0);
    tick();
    chk("rd_v_drop", b0.v_o, 0);
    tick();
    chk("rd_v1", b1.v_o, 4'b0010);
    chk("rd_a1", b1.a_o, 16'h0010);
    chk("rd_d1", b1.d_o, 16'hBEEF);
    chk("rd_a_hold", b0.a_o, 16'h0010);

    // all four ports, four reads each
    do_rst();
    for (int c = 0; c < 22; c++) begin
      if (c < 4) begin
        b0.v_i  = '1;
        b0.r_nw = '1;
        for (int p = 0; p < 4; p++)
          b0.a_i[p] = 16'(256 * p + c);
      end else idle();
      if (c >= 2 && c < 18) begin
        chk("rr_ramv",  b0.ram_v, 1);
        chk("rr_rama",  b0.ram_a, e0(c - 2));
        chk("fp_rama",  b1.ram_a, e1(c - 2));
      end
      if (c >= 4 && c < 20) begin
        chk("rr_v", b0.v_o, 32'(1 << ((c - 4) % 4)));
        chk("rr_a", b0.a_o, e0(c - 4));
        chk("rr_d", b0.d_o, 16'hA000 | e0(c - 4));
      end
      if (c >= 6) begin
        chk("fp_v", b1.v_o, 32'(1 << (3 - (c - 6) / 4)));
        chk("fp_a", b1.a_o, e1(c - 6));
        chk("fp_d", b1.d_o, 16'hA000 | e1(c - 6));
      end
      tick();
    end
    chk("rr_idle_v",  b0.ram_v, 0);
    chk("rr_idle_vo", b0.v_o, 0);
    chk("fp_idle_v",  b1.ram_v, 0);

    // port 2 overflow behind busy port 3
    do_rst();
    n2a = 0;
    n2b = 0;
    last2 = '0;
    for (int c = 0; c < 31; c++) begin
      b0.v_i = '0;
      b0.r_nw = '0;
      if (c < 10) begin
        b0.v_i[2] = 1'b1;
        b0.a_i[2] = 16'(16'h0200 + c);
        b0.d_i[2] = 16'(c);
      end
      if (c < 11) begin
        b0.v_i[3] = 1'b1;
        b0.a_i[3] = 16'(16'h0300 + c);
      end
      if (c == 7) chk("ovf_f7", b1.f_o[2], 0);
      if (c == 8) begin
        chk("ovf_f8", b1.f_o[2], 1);
        chk("ovf_o8", b1.ovf_o[2], 0);
        chk("ovf_rr_f8", b0.f_o, 0);
      end
      if (c == 9) chk("ovf_o9", b1.ovf_o, 4'b0100);
      if (b1.ram_v && b1.ram_a[15:8] == 8'h02) begin
        n2b++;
        last2 = b1.ram_a;
      end
      if (b0.ram_v && b0.ram_a[15:8] == 8'h02) n2a++;
      tick();
    end
    chk("ovf_cnt1",   n2b, 8);
    chk("ovf_last1",  last2, 16'h0207);
    chk("ovf_sticky", b1.ovf_o, 4'b0100);
    chk("ovf_fclr",   b1.f_o, 0);
    chk("ovf_cnt0",   n2a, 10);
    chk("ovf_rr_ovf", b0.ovf_o, 0);

    // reset with reads in flight
    do_rst();
    b0.v_i  = '1;
    b0.r_nw = '1;
    for (int p = 0; p < 4; p++)
      b0.a_i[p] = 16'(16'h0040 + p);
    tick();
    idle();
    tick();
    tick();
    chk("mr_busy", b0.ram_v, 1);
    rst = 1'b1;
    #1;
    chk("mr_ramv", b0.ram_v, 0);
    chk("mr_rama", b0.ram_a, 0);
    chk("mr_v",    b0.v_o, 0);
    chk("mr_a",    b0.a_o, 0);
    chk("mr_d",    b0.d_o, 0);
    chk("mr_ramv1", b1.ram_v, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("mr_nov",  b0.v_o, 0);
      chk("mr_nov1", b1.v_o, 0);
      chk("mr_nocmd", b0.ram_v, 0);
      chk("mr_nocmd1", b1.ram_v, 0);
      tick();
    end
    b0.v_i  = '1;
    b0.r_nw = '1;
    for (int p = 0; p < 4; p++)
      b0.a_i[p] = 16'(16'h0050 + p);
    tick();
    idle();
    tick();
    chk("mr_first",  b0.ram_a, 16'h0050);
    chk("mr_first1", b1.ram_a, 16'h0053);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arb_rr.md
Name: mem_arb_rr

Overview:
- N-port single-clock memory arbiter, successor to the fixed-priority FIFO arbiter.
- Each user port buffers read and write requests in its own FIFO.
- A selectable fixed-priority or round-robin arbiter issues at most one command per cycle to a single-port RAM.
- Read data is returned with the originating address and a one-hot per-port valid; the RAM read latency is a parameter.
- Sits between multiple masters (DMA, CPU, packet engines) and a shared SRAM/BRAM.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- N, 4, number of user ports (>=2).
- D, 8, per-port FIFO depth in entries; power of 2, >=2.
- RL, 1, RAM read latency in cycles from command to ram_q valid (>=1).
- RR, 1, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- v_i  in  N  per-port request strobe.
- r_nw  in  N  per-port opcode: 1 = read, 0 = write.
- a_i  in  N x AW  per-port address.
- d_i  in  N x DW  per-port write data.
- f_o  out  N  per-port FIFO full (registered).
- ovf_o  out  N  per-port sticky overflow.
- v_o  out  N  one-hot read-data valid, identifies the requesting port.
- a_o  out  AW  address of the returned read.
- d_o  out  DW  returned read data.
- ram_v  out  1  RAM command valid.
- ram_we  out  1  RAM write enable (only meaningful when ram_v=1).
- ram_a  out  AW  RAM address.
- ram_d  out  DW  RAM write data.
- ram_q  in  DW  RAM read data, valid RL cycles after a read command.

Behaviour:
- Reset, asynchronous: all FIFOs emptied; f_o=0, ovf_o=0, v_o=0, a_o=0, d_o=0, ram_v=0, ram_we=0, ram_a=0, ram_d=0; read-return pipeline cleared; RR pointer = N-1, so port 0 has first priority.
- Reset asserted mid-operation: in-flight reads are discarded and no v_o is produced for them.
- Enqueue: if v_i[i] && !f_o[i], the FIFO stores {d_i, a_i, r_nw}.
- Overflow: if v_i[i] && f_o[i], the request is dropped and ovf_o[i] is set until reset. A pop in the same cycle does not admit the write, because f_o is registered (count == D).
- Visibility: a written entry is visible to the arbiter the next cycle; there is no bypass.
- Arbitration, every cycle, over ports with non-empty FIFOs:
  - RR=0: the highest index wins.
  - RR=1: search starts at pointer+1 and wraps modulo N; the first non-empty port wins, and the pointer is updated to the winner only on a grant.
- No requesters: no grant, pointer unchanged, ram_v=0 next cycle.
- Grant: pops the winner's FIFO head in the grant cycle G.
- Command stage (registered): in cycle C=G+1, ram_v=1, ram_we=~r_nw, ram_a=addr, ram_d=data. Throughput is one command per cycle, back to back.
- Return pipeline: RL+1 stages carrying {one-hot port, addr, is_read}.
  - In cycle C+RL+1: d_o<=ram_q, a_o<=addr, v_o=one-hot if read.
  - Writes never raise v_o.
  - In cycles with no read return, v_o=0 and a_o/d_o hold their last value.
- Minimum latency: v_i at t gives ram_v at t+2 and v_o at t+3+RL.
- Ordering: per-port requests are served in order; read returns are in command order across all ports.
- FIFO pointers use log2(D)+1 bits; wrap-around is transparent. Full = count==D, empty = count==0.
- Simultaneous push and pop on the same FIFO: the count is unchanged and both operations take effect.

Optional Feature:
- Macro: MEM_ARB_RR_STAT_EN.
- Defined:
  - Adds output port gnt_cnt_o, N x 16, one wrapping grant counter per port.
  - Each counter increments on every grant to that port and resets to 0.
  - Adds output starve_o, N bits: bit i asserts while port i has been non-empty and ungranted for >=2*N consecutive cycles.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Single write then read, port 1, addr 0x0010 data 0xBEEF: ram_v/ram_we=1 at t+2; the read returns v_o=4'b0010, a_o=0x0010, d_o=0xBEEF at read-issue+3+RL.
- RR=1, all 4 ports request continuously with one read each per cycle: grant order 0,1,2,3,0,1..., ram_v held high, v_o cycles through one-hot 0001,0010,0100,1000.
- RR=0, ports 0 and 3 both loaded with 3 requests: all 3 of port 3 are issued before any of port 0.
- D=8, port 2 receives 10 back-to-back v_i with no grants (other ports busy or held): f_o[2]=1 after the 8th write; writes 9 and 10 are dropped, ovf_o[2]=1 and sticky; exactly 8 commands are issued for port 2.
- RL=3, reads issued at cycles 10,11,12: v_o asserted at cycles 14,15,16 with matching a_o.
- rst pulsed while 2 reads are in flight and FIFOs are non-empty: outputs are 0 immediately; no v_o after release; the next grant goes to port 0.
